// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Width of a counter that must hold values 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational "first set bit at or after start, wrapping N-1 -> 0" search.
module arb_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] idx,
    output logic           found
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(start) + i) % N]) begin
                found                        = 1'b1;
                idx                          = IDW'((int'(start) + i) % N);
                onehot[(int'(start) + i) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-requester arbiter with registered one-hot grant, fixed-priority or
// round-robin selection, and a bounded hold time while others are waiting.
//
//   state    | meaning
//   ARB_IDLE | no owner, grant outputs all zero
//   ARB_BUSY | owner_q holds the grant, hold_cnt counts its cycles
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    localparam int HCW = cnt_width(MAX_HOLD);

    arb_state_e     state_q;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] ptr_q;
    logic [HCW-1:0] hold_cnt;

    logic           owner_req;
    logic           others_req;
    logic           expired;
    logic [N-1:0]   pick_req;
    logic [IDW-1:0] pick_start;
    logic [N-1:0]   pick_onehot;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    logic [IDW-1:0] ptr_next;
    logic           new_grant;
    logic           go_idle;

    // grant is the registered one-hot of owner_q while busy, so it doubles as the owner mask
    assign owner_req  = req[owner_q];
    assign others_req = |(req & ~grant);
    assign expired    = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD));

    assign pick_req   = ((state_q == ARB_BUSY) && owner_req && expired) ? (req & ~grant) : req;
    assign pick_start = (mode == ARB_RR) ? ptr_q : '0;

    arb_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (pick_req),
        .start  (pick_start),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    assign ptr_next = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);

    always_comb begin
        new_grant = 1'b0;
        go_idle   = 1'b0;
        if (state_q == ARB_IDLE) begin
            new_grant = pick_found;
        end else if (!owner_req) begin
            new_grant = pick_found;
            go_idle   = !pick_found;
        end else if (expired) begin
            new_grant = others_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else if (new_grant) begin
            state_q     <= ARB_BUSY;
            owner_q     <= pick_idx;
            ptr_q       <= ptr_next;
            hold_cnt    <= HCW'(1);
            grant       <= pick_onehot;
            grant_valid <= 1'b1;
            grant_id    <= pick_idx;
        end else if (go_idle) begin
            state_q     <= ARB_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else if (state_q == ARB_BUSY) begin
            // expiry with nobody else waiting: owner keeps the grant and a fresh hold window
            if (expired) begin
                hold_cnt <= HCW'(1);
            end else begin
                hold_cnt <= hold_cnt + HCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench for rr_priority_arbiter (N=4, MAX_HOLD=4) against a behavioural model.
module tb_rr_priority_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = 2;

    logic           clk;
    logic           rst_n;
    logic           mode;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;

    int tests_run = 0;
    int fails     = 0;

    // model: owner index (-1 when idle), cycles held, round-robin start index
    int m_owner;
    int m_hold;
    int m_ptr;

    rr_priority_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
    endfunction

    function automatic void model_award(input int w);
        m_owner = w;
        m_hold  = 1;
        m_ptr   = (w + 1) % N;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic m);
        int start;
        int w;
        logic [N-1:0] others;
        start = m ? m_ptr : 0;
        if (m_owner < 0) begin
            w = model_pick(r, start);
            if (w >= 0) model_award(w);
        end else if (!r[m_owner]) begin
            w = model_pick(r, start);
            if (w >= 0) model_award(w);
            else m_owner = -1;
        end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD) begin
            others = r;
            others[m_owner] = 1'b0;
            if (others != '0) model_award(model_pick(others, start));
            else m_hold = 1;
        end else begin
            m_hold = m_hold + 1;
        end
    endfunction

    function automatic logic [N+IDW:0] model_outputs();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, (m_owner >= 0), IDW'((m_owner >= 0) ? m_owner : 0)};
    endfunction

    // one clock: drive on the falling edge, advance the model at the rising edge, settle 1 time unit
    task automatic cyc(input logic [N-1:0] r, input logic m);
        @(negedge clk);
        req  = r;
        mode = m;
        @(posedge clk);
        model_step(r, m);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        mode  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        mode  = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if ({grant, grant_valid, grant_id} !== '0) begin
                fails++;
                $display("FAIL reset_hold: got grant=%b valid=%b id=%0d, want all zero", grant, grant_valid, grant_id);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1111, 1'b1);
        tests_run++;
        if ({grant, grant_valid, grant_id} !== {4'b0001, 1'b1, 2'd0}) begin
            fails++;
            $display("FAIL reset_first_arb: got grant=%b valid=%b id=%0d, want 0001/1/0", grant, grant_valid, grant_id);
        end
    endtask

    task automatic test_fixed_priority();
        logic [N-1:0] seq_req [3] = '{4'b1010, 4'b1010, 4'b1000};
        logic [N-1:0] seq_exp [3] = '{4'b0010, 4'b0010, 4'b1000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(seq_req[i], 1'b0);
            tests_run++;
            if (grant !== seq_exp[i] || grant_valid !== 1'b1 || {grant, grant_valid, grant_id} !== model_outputs()) begin
                fails++;
                $display("FAIL fixed_prio step %0d: got grant=%b id=%0d, want %b", i, grant, grant_id, seq_exp[i]);
            end
        end
    endtask

    task automatic test_rr_rotation();
        logic [N-1:0] want;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            cyc(4'b1111, 1'b1);
            want = 4'(1 << (((c - 1) / MAX_HOLD) % N));
            tests_run++;
            if (grant !== want || {grant, grant_valid, grant_id} !== model_outputs()) begin
                fails++;
                $display("FAIL rr_rotation cyc %0d: got grant=%b id=%0d, want %b", c, grant, grant_id, want);
            end
        end
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        cyc(4'b0100, 1'b1);
        tests_run++;
        if (grant !== 4'b0100 || grant_id !== 2'd2) begin
            fails++;
            $display("FAIL ptr_wrap_setup: got grant=%b id=%0d, want 0100/2", grant, grant_id);
        end
        cyc(4'b0011, 1'b1);
        tests_run++;
        if (grant !== 4'b0001 || grant_id !== 2'd0 || grant_valid !== 1'b1) begin
            fails++;
            $display("FAIL ptr_wrap: got grant=%b id=%0d, want 0001/0", grant, grant_id);
        end
    endtask

    task automatic test_expiry_no_contention();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            cyc(4'b0100, c[0]);
            tests_run++;
            if (grant !== 4'b0100 || grant_valid !== 1'b1 || grant_id !== 2'd2) begin
                fails++;
                $display("FAIL expiry_solo cyc %0d: got grant=%b valid=%b id=%0d, want 0100/1/2", c, grant, grant_valid, grant_id);
            end
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        cyc(4'b0010, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            cyc(4'b1111, 1'b1);
            tests_run++;
            if (grant !== ((c < 4) ? 4'b0010 : 4'b0100) || {grant, grant_valid, grant_id} !== model_outputs()) begin
                fails++;
                $display("FAIL mode_switch cyc %0d: got grant=%b, want %b", c, grant, (c < 4) ? 4'b0010 : 4'b0100);
            end
        end
    endtask

    task automatic test_regrant_same_index();
        do_reset();
        // a lone requester toggling 1-0-1 is a fresh grant each time, restarting its hold window
        cyc(4'b0001, 1'b1);
        cyc(4'b0000, 1'b1);
        tests_run++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL regrant_idle: got grant=%b valid=%b, want 0000/0", grant, grant_valid);
        end
        cyc(4'b0001, 1'b1);
        for (int c = 0; c < 3; c++) cyc(4'b0011, 1'b1);
        tests_run++;
        if (grant !== 4'b0001 || {grant, grant_valid, grant_id} !== model_outputs()) begin
            fails++;
            $display("FAIL regrant_hold: got grant=%b, want 0001", grant);
        end
        cyc(4'b0011, 1'b1);
        tests_run++;
        if (grant !== 4'b0010) begin
            fails++;
            $display("FAIL regrant_expiry: got grant=%b, want 0010", grant);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        cyc(4'b0100, 1'b0);
        tests_run++;
        if (grant !== 4'b0100) begin
            fails++;
            $display("FAIL mid_reset_setup: got grant=%b, want 0100", grant);
        end
        #2;
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        #1;
        tests_run++;
        if ({grant, grant_valid, grant_id} !== '0) begin
            fails++;
            $display("FAIL mid_reset_async: got grant=%b valid=%b id=%0d, want all zero", grant, grant_valid, grant_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b0100, 1'b0);
        tests_run++;
        if ({grant, grant_valid, grant_id} !== {4'b0100, 1'b1, 2'd2}) begin
            fails++;
            $display("FAIL mid_reset_regrant: got grant=%b valid=%b id=%0d, want 0100/1/2", grant, grant_valid, grant_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         m;
        do_reset();
        r = '0;
        m = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) m = ~m;
            cyc(r, m);
            tests_run++;
            if ({grant, grant_valid, grant_id} !== model_outputs() || !$onehot0(grant)) begin
                fails++;
                $display("FAIL random cyc %0d req=%b mode=%b: got grant=%b valid=%b id=%0d, want %b",
                         c, r, m, grant, grant_valid, grant_id, model_outputs());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        mode  = 1'b0;
        model_reset();
        test_reset();
        test_fixed_priority();
        test_rr_rotation();
        test_pointer_wrap();
        test_expiry_no_contention();
        test_mode_switch();
        test_regrant_same_index();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
